// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one request in flight, small registered FIFO toward decode.
// Redirects flush the buffer and any in-flight fetch.
module fetch_unit #(
  parameter int unsigned         XLEN       = 32,
  parameter logic [XLEN-1:0]     RESET_PC   = '0,
  parameter int unsigned         FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] current_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t          state;
  logic [XLEN-1:0] req_pc;
  logic [CW-1:0]   count;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [XLEN-1:0] buf_data [FIFO_DEPTH];
  logic [XLEN-1:0] buf_pc   [FIFO_DEPTH];

  logic handshake;
  logic push;
  logic pop;

  // Gating with reset keeps the request quiet while the async reset is held.
  always_comb begin
    imem_req_valid = reset && (state == IDLE) && !redirect_valid && (count < FULL);
    imem_req_addr  = current_pc;
    handshake      = imem_req_valid && imem_req_ready;
    push           = (state == WAIT) && imem_resp_valid && !redirect_valid;
    inst_valid     = (count != '0);
    pop            = inst_valid && inst_ready && !redirect_valid;
    inst_data      = inst_valid ? buf_data[rd_ptr] : '0;
    inst_pc        = inst_valid ? buf_pc[rd_ptr]   : '0;
  end

  always_comb begin
    if (!reset)              next_pc = RESET_PC;
    else if (redirect_valid) next_pc = redirect_pc;
    else if (handshake)      next_pc = current_pc + XLEN'(4);
    else                     next_pc = current_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      req_pc <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            state  <= WAIT;
            req_pc <= current_pc;
          end
        end
        WAIT: begin
          if (imem_resp_valid)     state <= IDLE;
          else if (redirect_valid) state <= DROP;
        end
        DROP: begin
          if (imem_resp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (redirect_valid) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: contents are only visible when count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= imem_resp_data;
      buf_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table, directed redirect/reset sequences, and a random
// run scored against a queue-based model of the fetch stream.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] current_pc = 32'h100;
  logic [31:0] next_pc;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int unsigned total = 0;
  int unsigned passed = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .current_pc(current_pc), .next_pc(next_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  // The pc block: loads next_pc every edge.
  always @(posedge clk) current_pc <= next_pc;

  typedef struct packed {
    logic        rst, rr, rv;
    logic [31:0] rd;
    logic        ir;
    logic [31:0] nx, addr;
    logic        req, iv;
    logic [31:0] ipc, idat;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  function automatic vec_t v(logic rst, logic rr, logic rv, logic [31:0] rd, logic ir,
                             logic [31:0] nx, logic [31:0] addr, logic req, logic iv,
                             logic [31:0] ipc, logic [31:0] idat);
    vec_t r;
    r.rst = rst; r.rr = rr; r.rv = rv; r.rd = rd; r.ir = ir;
    r.nx = nx; r.addr = addr; r.req = req; r.iv = iv; r.ipc = ipc; r.idat = idat;
    return r;
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  // Inputs change mid-cycle (negedge); outputs are sampled 2 ns later, well before posedge.
  task automatic drive(input logic rst_v, input logic rr, input logic rv,
                       input logic [31:0] rd, input logic redir, input logic [31:0] rpc,
                       input logic ir);
    @(negedge clk);
    reset           = rst_v;
    imem_req_ready  = rr;
    imem_resp_valid = rv;
    imem_resp_data  = rd;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    inst_ready      = ir;
    #2;
  endtask

  vec_t        tbl [22];
  ent_t        q[$];
  ent_t        e;
  logic        busy, doomed, rr_v, rv_v, redir_v, ir_v, exp_req, do_pop;
  logic [31:0] maddr, rd_v, rpc_v, exp_next;
  int unsigned lat;

  initial begin
    // rst rr rv rd ir | next_pc addr req iv inst_pc inst_data
    tbl[0]  = v(0,0,0,32'h0 ,1, 32'h0,32'h0,0,0,32'h0,32'h0);
    tbl[1]  = v(0,0,0,32'h0 ,1, 32'h0,32'h0,0,0,32'h0,32'h0);
    tbl[2]  = v(1,0,0,32'h0 ,1, 32'h0,32'h0,1,0,32'h0,32'h0);
    tbl[3]  = v(1,1,0,32'h0 ,1, 32'h4,32'h0,1,0,32'h0,32'h0);
    tbl[4]  = v(1,1,1,32'h11,1, 32'h4,32'h4,0,0,32'h0,32'h0);
    tbl[5]  = v(1,1,0,32'h0 ,1, 32'h8,32'h4,1,1,32'h0,32'h11);
    tbl[6]  = v(1,1,1,32'h22,1, 32'h8,32'h8,0,0,32'h0,32'h0);
    tbl[7]  = v(1,1,0,32'h0 ,1, 32'hC,32'h8,1,1,32'h4,32'h22);
    tbl[8]  = v(1,1,1,32'h33,1, 32'hC,32'hC,0,0,32'h0,32'h0);
    tbl[9]  = v(1,0,0,32'h0 ,1, 32'hC,32'hC,1,1,32'h8,32'h33);
    tbl[10] = v(1,0,0,32'h0 ,1, 32'hC,32'hC,1,0,32'h0,32'h0);
    tbl[11] = v(0,0,0,32'h0 ,0, 32'h0,32'hC,0,0,32'h0,32'h0);
    tbl[12] = v(1,1,0,32'h0 ,0, 32'h4,32'h0,1,0,32'h0,32'h0);
    tbl[13] = v(1,1,1,32'hA1,0, 32'h4,32'h4,0,0,32'h0,32'h0);
    tbl[14] = v(1,1,0,32'h0 ,0, 32'h8,32'h4,1,1,32'h0,32'hA1);
    tbl[15] = v(1,1,1,32'hA2,0, 32'h8,32'h8,0,1,32'h0,32'hA1);
    tbl[16] = v(1,1,0,32'h0 ,0, 32'h8,32'h8,0,1,32'h0,32'hA1);
    tbl[17] = v(1,1,0,32'h0 ,0, 32'h8,32'h8,0,1,32'h0,32'hA1);
    tbl[18] = v(1,1,0,32'h0 ,1, 32'h8,32'h8,0,1,32'h0,32'hA1);
    tbl[19] = v(1,1,0,32'h0 ,1, 32'hC,32'h8,1,1,32'h4,32'hA2);
    tbl[20] = v(1,1,1,32'hA3,1, 32'hC,32'hC,0,0,32'h0,32'h0);
    tbl[21] = v(1,0,0,32'h0 ,1, 32'hC,32'hC,1,1,32'h8,32'hA3);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rst, tbl[i].rr, tbl[i].rv, tbl[i].rd, 1'b0, 32'h0, tbl[i].ir);
      chk($sformatf("row%0d next_pc", i), next_pc, tbl[i].nx);
      chk($sformatf("row%0d req_addr", i), imem_req_addr, tbl[i].addr);
      chk($sformatf("row%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].req});
      chk($sformatf("row%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].iv});
      chk($sformatf("row%0d inst_pc", i), inst_pc, tbl[i].ipc);
      chk($sformatf("row%0d inst_data", i), inst_data, tbl[i].idat);
    end

    // Redirect to 0xA0 while waiting, with one entry buffered.
    drive(1, 1, 0, 32'h0,   0, 32'h0,  0); chk("t4 next_pc a", next_pc, 32'h10);
    drive(1, 0, 1, 32'h55,  0, 32'h0,  0);
    drive(1, 1, 0, 32'h0,   0, 32'h0,  0); chk("t4 inst_valid pre", {31'b0, inst_valid}, 32'h1);
                                           chk("t4 next_pc c", next_pc, 32'h14);
    drive(1, 1, 0, 32'h0,   1, 32'hA0, 1); chk("t4 redirect next_pc", next_pc, 32'hA0);
                                           chk("t4 redirect req_valid", {31'b0, imem_req_valid}, 32'h0);
    drive(1, 1, 0, 32'h0,   0, 32'h0,  1); chk("t4 flushed inst_valid", {31'b0, inst_valid}, 32'h0);
                                           chk("t4 drop req_valid", {31'b0, imem_req_valid}, 32'h0);
                                           chk("t4 drop next_pc", next_pc, 32'hA0);
    drive(1, 1, 1, 32'hBAD, 0, 32'h0,  1); chk("t4 late resp req_valid", {31'b0, imem_req_valid}, 32'h0);
    drive(1, 1, 0, 32'h0,   0, 32'h0,  1); chk("t4 late dropped", {31'b0, inst_valid}, 32'h0);
                                           chk("t4 refetch addr", imem_req_addr, 32'hA0);
                                           chk("t4 refetch next_pc", next_pc, 32'hA4);
    drive(1, 0, 1, 32'h66,  0, 32'h0,  0);
    drive(1, 0, 0, 32'h0,   0, 32'h0,  1); chk("t4 first inst_pc", inst_pc, 32'hA0);
                                           chk("t4 first inst_data", inst_data, 32'h66);

    // Redirect coincident with the response; target also exercises pc wrap.
    drive(1, 1, 0, 32'h0,   0, 32'h0,  1);
    drive(1, 0, 1, 32'h77,  1, 32'hFFFF_FFFC, 1); chk("t5 next_pc", next_pc, 32'hFFFF_FFFC);
    drive(1, 1, 0, 32'h0,   0, 32'h0,  1); chk("t5 not pushed", {31'b0, inst_valid}, 32'h0);
                                           chk("t5 idle req_valid", {31'b0, imem_req_valid}, 32'h1);
                                           chk("t5 addr", imem_req_addr, 32'hFFFF_FFFC);
                                           chk("t5 wrap next_pc", next_pc, 32'h0);
    drive(1, 0, 1, 32'h88,  0, 32'h0,  0);
    drive(1, 0, 0, 32'h0,   0, 32'h0,  1); chk("t5 inst_pc", inst_pc, 32'hFFFF_FFFC);
                                           chk("t5 inst_data", inst_data, 32'h88);

    // Reset pulse while a fetch is outstanding and the FIFO holds an entry.
    drive(1, 1, 0, 32'h0,   0, 32'h0,  0);
    drive(1, 0, 1, 32'h99,  0, 32'h0,  0);
    drive(1, 1, 0, 32'h0,   0, 32'h0,  0); chk("t6 pre inst_valid", {31'b0, inst_valid}, 32'h1);
    drive(0, 0, 0, 32'h0,   0, 32'h0,  0); chk("t6 rst next_pc", next_pc, 32'h0);
                                           chk("t6 rst req_valid", {31'b0, imem_req_valid}, 32'h0);
                                           chk("t6 rst inst_valid", {31'b0, inst_valid}, 32'h0);
                                           chk("t6 rst inst_data", inst_data, 32'h0);
    drive(0, 0, 0, 32'h0,   0, 32'h0,  0);
    drive(1, 0, 1, 32'hBAD, 0, 32'h0,  0); chk("t6 idle req_valid", {31'b0, imem_req_valid}, 32'h1);
    drive(1, 0, 0, 32'h0,   0, 32'h0,  0); chk("t6 stale ignored", {31'b0, inst_valid}, 32'h0);
                                           chk("t6 stale data", inst_data, 32'h0);

    // Random run against a stream-level model.
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
    busy = 1'b0; doomed = 1'b0; maddr = '0; lat = 0; q.delete();
    for (int n = 0; n < 600; n++) begin
      rv_v    = busy && (lat == 0);
      rd_v    = rv_v ? mem_word(maddr) : $urandom;
      rr_v    = ($urandom_range(0, 9) < 7);
      redir_v = ($urandom_range(0, 11) == 0);
      rpc_v   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
      ir_v    = ($urandom_range(0, 9) < 6);
      drive(1, rr_v, rv_v, rd_v, redir_v, rpc_v, ir_v);

      exp_req  = !busy && !redir_v && (q.size() < DEPTH);
      exp_next = redir_v ? rpc_v : (exp_req && rr_v) ? current_pc + 32'd4 : current_pc;
      chk("rnd next_pc", next_pc, exp_next);
      chk("rnd req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
      chk("rnd req_addr", imem_req_addr, current_pc);
      chk("rnd inst_valid", {31'b0, inst_valid}, (q.size() != 0) ? 32'h1 : 32'h0);
      chk("rnd inst_pc", inst_pc, (q.size() != 0) ? q[0].pc : 32'h0);
      chk("rnd inst_data", inst_data, (q.size() != 0) ? q[0].data : 32'h0);

      do_pop = (q.size() != 0) && ir_v;
      if (redir_v) begin
        q.delete();
        if (busy && !rv_v) doomed = 1'b1;
      end else begin
        if (do_pop) void'(q.pop_front());
        if (rv_v && !doomed) begin
          e.pc = maddr; e.data = rd_v;
          q.push_back(e);
        end
      end
      if (rv_v) begin
        busy = 1'b0; doomed = 1'b0;
      end else if (busy) begin
        lat--;
      end
      if (exp_req && rr_v) begin
        busy = 1'b1; doomed = 1'b0; maddr = current_pc; lat = $urandom_range(0, 2);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
